// File: rtl/riscv_cpu_pkg.sv
// Shared RV32I definitions for the CPU pipeline stages.
//   INSTR_WIDTH : instruction word width
//   NOP_INSTR   : canonical NOP (addi x0, x0, 0), used as the ID/EX reset value
//   opcode_e    : base-ISA major opcodes
//   uses_rs1 / uses_rs2 / writes_rd : source/destination usage per opcode
package riscv_cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  // Every opcode reads rs1 except the ones that build their result from the PC/immediate alone.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  endfunction

  // SYSTEM counts as a writer because CSR accesses return the old CSR value in rd.
  function automatic logic writes_rd(input logic [6:0] opcode);
    return opcode inside {OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR,
                          OPC_LUI, OPC_AUIPC, OPC_SYSTEM};
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Operand selection for one register source (pure combinational).
//   src_i                         : source register index
//   rdata_i                       : register_file read data for src_i
//   exf_valid_i/exf_rd_i/exf_data_i : in-flight result in EX/MEM
//   wb_we_i/wb_waddr_i/wb_wdata_i   : result being committed this cycle
//   operand_o                     : resolved value (x0 -> 0, then EX/MEM, then WB, then register_file)
//   exf_hit_o / wb_hit_o          : src_i matches the EX/MEM / WB destination (never for x0)
// With FWD_EN=0 the hits are still reported so the caller can stall, but the
// operand always comes from the register file.
module operand_bypass #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          FWD_EN     = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] src_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  exf_valid_i,
  input  logic [ADDR_WIDTH-1:0] exf_rd_i,
  input  logic [DATA_WIDTH-1:0] exf_data_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i,
  output logic [DATA_WIDTH-1:0] operand_o,
  output logic                  exf_hit_o,
  output logic                  wb_hit_o
);

  logic src_is_x0;

  assign src_is_x0 = (src_i == '0);
  assign exf_hit_o = !src_is_x0 && exf_valid_i && (exf_rd_i == src_i);
  assign wb_hit_o  = !src_is_x0 && wb_we_i && (wb_waddr_i == src_i);

  always_comb begin
    // NOTE: assigning a default before any branch keeps every path covered, so no latch is inferred.
    operand_o = rdata_i;
    if (src_is_x0) begin
      // register_file has no hardwired zero, so x0 is forced here.
      operand_o = '0;
    end else if (FWD_EN && exf_hit_o) begin
      operand_o = exf_data_i;
    end else if (FWD_EN && wb_hit_o) begin
      // The register file only commits at the edge, so a same-cycle write must be bypassed.
      operand_o = wb_wdata_i;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch (ID) stage.
//   in_*      : instruction from fetch (valid/ready)
//   raddr_*_o / rdata_*_i : register_file read ports (rs1 on A, rs2 on B)
//   exf_*     : EX/MEM result for bypass; exf_dready_i=0 while a load is in flight
//   wb_*      : register_file write port, bypassed because the write lands at the edge
//   flush_i   : kills ID/EX and the current input
//   out_*     : ID/EX pipeline register towards execute (valid/ready)
// RAW hazards that cannot be bypassed stall the input and insert a bubble downstream.
module operand_fetch_stage
  import riscv_cpu_pkg::*;
#(
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [INSTR_WIDTH-1:0] in_instr_i,
  input  logic [31:0]            in_pc_i,
  output logic [ADDR_WIDTH-1:0]  raddr_a_o,
  input  logic [DATA_WIDTH-1:0]  rdata_a_i,
  output logic [ADDR_WIDTH-1:0]  raddr_b_o,
  input  logic [DATA_WIDTH-1:0]  rdata_b_i,
  input  logic                   exf_valid_i,
  input  logic [ADDR_WIDTH-1:0]  exf_rd_i,
  input  logic [DATA_WIDTH-1:0]  exf_data_i,
  input  logic                   exf_dready_i,
  input  logic                   wb_we_i,
  input  logic [ADDR_WIDTH-1:0]  wb_waddr_i,
  input  logic [DATA_WIDTH-1:0]  wb_wdata_i,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [INSTR_WIDTH-1:0] out_instr_o,
  output logic [31:0]            out_pc_o,
  output logic [DATA_WIDTH-1:0]  out_op_a_o,
  output logic [DATA_WIDTH-1:0]  out_op_b_o
);

  logic [ADDR_WIDTH-1:0]  rs1, rs2, pend_rd;
  logic                   use_rs1, use_rs2, pend_write;
  logic [DATA_WIDTH-1:0]  op_a, op_b;
  logic                   exf_hit_a, wb_hit_a, exf_hit_b, wb_hit_b;
  logic                   haz_a, haz_b, hazard, advance, transfer;

  logic                   out_valid_d, out_valid_q;
  logic [INSTR_WIDTH-1:0] out_instr_d, out_instr_q;
  logic [31:0]            out_pc_d, out_pc_q;
  logic [DATA_WIDTH-1:0]  out_op_a_d, out_op_a_q;
  logic [DATA_WIDTH-1:0]  out_op_b_d, out_op_b_q;

  assign rs1       = ADDR_WIDTH'(in_instr_i[19:15]);
  assign rs2       = ADDR_WIDTH'(in_instr_i[24:20]);
  assign raddr_a_o = rs1;
  assign raddr_b_o = rs2;
  assign use_rs1   = uses_rs1(in_instr_i[6:0]);
  assign use_rs2   = uses_rs2(in_instr_i[6:0]);

  operand_bypass #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .FWD_EN(FWD_EN)
  ) u_bypass_a (
    .src_i(rs1), .rdata_i(rdata_a_i),
    .exf_valid_i(exf_valid_i), .exf_rd_i(exf_rd_i), .exf_data_i(exf_data_i),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .operand_o(op_a), .exf_hit_o(exf_hit_a), .wb_hit_o(wb_hit_a)
  );

  operand_bypass #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .FWD_EN(FWD_EN)
  ) u_bypass_b (
    .src_i(rs2), .rdata_i(rdata_b_i),
    .exf_valid_i(exf_valid_i), .exf_rd_i(exf_rd_i), .exf_data_i(exf_data_i),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .operand_o(op_b), .exf_hit_o(exf_hit_b), .wb_hit_o(wb_hit_b)
  );

  // The instruction sitting in ID/EX has not produced its result yet, so a
  // consumer directly behind it must wait one cycle regardless of FWD_EN.
  assign pend_rd    = ADDR_WIDTH'(out_instr_q[11:7]);
  assign pend_write = out_valid_q && writes_rd(out_instr_q[6:0]) && (pend_rd != '0);

  assign haz_a = use_rs1 && ((pend_write && (pend_rd == rs1))
                             || (exf_hit_a && (!exf_dready_i || !FWD_EN))
                             || (wb_hit_a && !FWD_EN));
  assign haz_b = use_rs2 && ((pend_write && (pend_rd == rs2))
                             || (exf_hit_b && (!exf_dready_i || !FWD_EN))
                             || (wb_hit_b && !FWD_EN));
  assign hazard = haz_a || haz_b;

  assign advance    = !out_valid_q || out_ready_i;
  // A flush always "accepts" the input so fetch drops it instead of re-presenting it.
  assign in_ready_o = flush_i || (advance && !hazard);
  assign transfer   = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_op_a_d  = out_op_a_q;
    out_op_b_d  = out_op_b_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (advance) begin
      // No transfer while advancing (hazard or idle input) leaves a bubble.
      out_valid_d = transfer;
      if (transfer) begin
        out_instr_d = in_instr_i;
        out_pc_d    = in_pc_i;
        out_op_a_d  = op_a;
        out_op_b_d  = op_b;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // NOTE: the whole ID/EX register is reset, so an async reset mid-stall leaves no stale payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= '0;
      out_op_a_q  <= '0;
      out_op_b_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_op_a_q  <= out_op_a_d;
      out_op_b_q  <= out_op_b_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_instr_o = out_instr_q;
  assign out_pc_o    = out_pc_q;
  assign out_op_a_o  = out_op_a_q;
  assign out_op_b_o  = out_op_b_q;

endmodule
